sb_serializer: RTL and testbench

Sideband transmit serializer: accepts one WIDTH-bit message over a valid/ready handshake and shifts it out LSB-first, one bit per clk. It pairs with the sideband deserializer on the far end, which samples on the falling edge, so this block drives data on the rising edge. During transmission it also asserts a clock-enable that gates the forwarded sideband clock, and it enforces a minimum idle gap between messages.

---
 rtl/sb_serializer_pkg.sv | 15 +
 rtl/sb_serializer.sv | 126 ++++++++++++
 tb/tb_sb_serializer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_serializer_pkg.sv
// Shared sideband definitions: serializer FSM states and link defaults
// common to the serializer and its far-end deserializer.
package sb_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } sb_ser_state_e;

    localparam int SB_MSG_WIDTH  = 128;
    localparam int SB_GAP_CYCLES = 32;
    localparam int SB_PKT_CNT_W  = 16;

endpackage

// File: rtl/sb_serializer.sv
// Sideband TX serializer: LSB-first shift-out with forwarded-clock gate and idle gap.
// Optional transmitted-packet counter port enabled by SB_SERIALIZER_PKT_CNT_EN.
module sb_serializer
    import sb_serializer_pkg::*;
#(
    parameter int WIDTH      = SB_MSG_WIDTH,
    parameter int GAP_CYCLES = SB_GAP_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_data,
    output logic                    out_clk_en,
    output logic                    tx_done
`ifdef SB_SERIALIZER_PKT_CNT_EN
    ,
    output logic [SB_PKT_CNT_W-1:0] tx_pkt_count
`endif
);

    localparam int CNT_W = $clog2((WIDTH > GAP_CYCLES + 1) ? WIDTH : GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sb_ser_state_e    r_state;
    sb_ser_state_e    w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_out_data;
    logic             w_out_data_nxt;
    logic             r_clk_en;
    logic             w_clk_en_nxt;
    logic             r_tx_done;
    logic             w_tx_done_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are registered from the current shift-register LSB, so bit i
    // appears one edge after the shift register holds it at position 0.
    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_cnt_nxt      = r_cnt;
        w_out_data_nxt = 1'b0;
        w_clk_en_nxt   = 1'b0;
        w_tx_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_shreg_nxt = in_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_out_data_nxt = r_shreg[0];
                w_clk_en_nxt   = 1'b1;
                w_shreg_nxt    = r_shreg >> 1;
                if (r_cnt == LAST_BIT) begin
                    w_tx_done_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == LAST_GAP) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_out_data <= 1'b0;
            r_clk_en   <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_shreg    <= w_shreg_nxt;
            r_cnt      <= w_cnt_nxt;
            r_out_data <= w_out_data_nxt;
            r_clk_en   <= w_clk_en_nxt;
            r_tx_done  <= w_tx_done_nxt;
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_data   = r_out_data;
    assign out_clk_en = r_clk_en;
    assign tx_done    = r_tx_done;

`ifdef SB_SERIALIZER_PKT_CNT_EN
    logic [SB_PKT_CNT_W-1:0] r_pkt_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt <= '0;
        end else if (r_tx_done) begin
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
        end
    end

    assign tx_pkt_count = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_sb_serializer.sv
// Directed self-checking bench for sb_serializer: a 128-bit/gap-32 instance
// and an 8-bit/gap-0 instance, checked through a negedge-sampling receiver.
module tb_sb_serializer;
    import sb_serializer_pkg::*;

    localparam int WA = 128;
    localparam int GA = 32;
    localparam int WB = 8;
    localparam int GB = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic [WA-1:0] a_data;
    logic          a_valid, a_ready, a_out, a_en, a_done;
    logic [WB-1:0] b_data;
    logic          b_valid, b_ready, b_out, b_en, b_done;
`ifdef SB_SERIALIZER_PKT_CNT_EN
    logic [15:0]   a_cnt, b_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sb_serializer #(.WIDTH(WA), .GAP_CYCLES(GA)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .out_data(a_out), .out_clk_en(a_en), .tx_done(a_done)
`ifdef SB_SERIALIZER_PKT_CNT_EN
        , .tx_pkt_count(a_cnt)
`endif
    );

    sb_serializer #(.WIDTH(WB), .GAP_CYCLES(GB)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .out_data(b_out), .out_clk_en(b_en), .tx_done(b_done)
`ifdef SB_SERIALIZER_PKT_CNT_EN
        , .tx_pkt_count(b_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One message on instance A; c=0 is the negedge right after the accepting edge.
    task automatic run_a(input logic [WA-1:0] d, output logic [WA-1:0] got,
                         output int en_n, output int first_en, output int done_n,
                         output int done_at, output int rdy_low);
        bit rdy_run = 1'b1;
        got = '0; en_n = 0; first_en = -1; done_n = 0; done_at = -1; rdy_low = 0;
        @(negedge clk);
        a_data  = d;
        a_valid = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_data  = ~d;
        for (int c = 0; c < WA + GA + 8; c++) begin
            @(negedge clk);
            if (a_en) begin
                if (first_en < 0) first_en = c;
                if (en_n < WA) got[en_n] = a_out;
                en_n++;
            end
            if (a_done) begin
                done_n++;
                done_at = c;
            end
            if (rdy_run && !a_ready) rdy_low++;
            else rdy_run = 1'b0;
        end
    endtask

    task automatic two_a(input logic [WA-1:0] m1, input logic [WA-1:0] m2,
                         output logic [WA-1:0] got2, output int gap_low,
                         output int gap_bad, output int n_done);
        int acc = 0;
        int phase = 0;
        int idx = 0;
        got2 = '0; gap_low = 0; gap_bad = 0; n_done = 0;
        @(negedge clk);
        a_data  = m1;
        a_valid = 1'b1;
        for (int c = 0; c < 2 * (WA + GA) + 20; c++) begin
            if (a_ready && a_valid) begin
                @(posedge clk);
                #1;
                acc++;
                if (acc == 1) a_data = m2;
                else a_valid = 1'b0;
            end
            @(negedge clk);
            if (a_done) n_done++;
            case (phase)
                0: if (a_done) phase = 1;
                1: begin
                    if (!a_en) begin
                        gap_low++;
                        if (a_out) gap_bad++;
                    end else begin
                        phase = 2;
                        got2[idx] = a_out;
                        idx++;
                    end
                end
                default: begin
                    if (a_en && idx < WA) begin
                        got2[idx] = a_out;
                        idx++;
                    end
                end
            endcase
        end
        a_valid = 1'b0;
    endtask

    task automatic two_b(input logic [WB-1:0] m1, input logic [WB-1:0] m2,
                         output logic [WB-1:0] got2, output int gap_low,
                         output int gap_bad, output int n_done);
        int acc = 0;
        int phase = 0;
        int idx = 0;
        got2 = '0; gap_low = 0; gap_bad = 0; n_done = 0;
        @(negedge clk);
        b_data  = m1;
        b_valid = 1'b1;
        for (int c = 0; c < 2 * (WB + GB) + 20; c++) begin
            if (b_ready && b_valid) begin
                @(posedge clk);
                #1;
                acc++;
                if (acc == 1) b_data = m2;
                else b_valid = 1'b0;
            end
            @(negedge clk);
            if (b_done) n_done++;
            case (phase)
                0: if (b_done) phase = 1;
                1: begin
                    if (!b_en) begin
                        gap_low++;
                        if (b_out) gap_bad++;
                    end else begin
                        phase = 2;
                        got2[idx] = b_out;
                        idx++;
                    end
                end
                default: begin
                    if (b_en && idx < WB) begin
                        got2[idx] = b_out;
                        idx++;
                    end
                end
            endcase
        end
        b_valid = 1'b0;
    endtask

    initial begin
        logic [WA-1:0] got, pat, q;
        logic [WB-1:0] gotb;
        int en_n, first_en, done_n, done_at, rdy_low, gap_low, gap_bad, n_done, dn;

        rst = 1'b1;
        a_data = '0; a_valid = 1'b0;
        b_data = '0; b_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_ready", 128'(a_ready), 128'd1);
        chk("rst_a_out",   128'(a_out),   128'd0);
        chk("rst_a_en",    128'(a_en),    128'd0);
        chk("rst_a_done",  128'(a_done),  128'd0);
        chk("rst_b_ready", 128'(b_ready), 128'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_a_ready", 128'(a_ready), 128'd1);

        // Single bit message
        run_a(128'h1, got, en_n, first_en, done_n, done_at, rdy_low);
        chk("one_word",      got, 128'h1);
        chk_i("one_en_cnt",  en_n, WA);
        chk_i("one_first",   first_en, 1);
        chk_i("one_done_n",  done_n, 1);
        chk_i("one_done_at", done_at, WA);
        chk_i("one_rdy_low", rdy_low, WA + GA);

        // Alternating pattern through the receiver model
        pat = {16{8'hA5}};
        run_a(pat, got, en_n, first_en, done_n, done_at, rdy_low);
        chk("a5_word",      got, pat);
        chk_i("a5_rdy_low", rdy_low, WA + GA);
        chk_i("a5_en_cnt",  en_n, WA);

        // Back-to-back with valid held: GAP state plus the accepting IDLE cycle
        two_a(128'hDEADBEEF_00000000_12345678_9ABCDEF0, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0,
              got, gap_low, gap_bad, n_done);
        chk("b2b_a_word2",    got, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
        chk_i("b2b_a_gap",    gap_low, GA + 1);
        chk_i("b2b_a_gapbad", gap_bad, 0);
        chk_i("b2b_a_done",   n_done, 2);

        // Zero gap: clock gate drops for exactly one cycle
        two_b(8'hC3, 8'h5A, gotb, gap_low, gap_bad, n_done);
        chk("b2b_b_word2",    128'(gotb), 128'h5A);
        chk_i("b2b_b_gap",    gap_low, 1);
        chk_i("b2b_b_gapbad", gap_bad, 0);
        chk_i("b2b_b_done",   n_done, 2);

        // Reset in the middle of a message, at bit 60
        pat = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        @(negedge clk);
        a_data  = pat;
        a_valid = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        repeat (62) @(negedge clk);
        chk("mid_en",  128'(a_en),  128'd1);
        chk("mid_bit", 128'(a_out), 128'(pat[60]));
        rst = 1'b1;
        #1;
        chk("arst_out",   128'(a_out),   128'd0);
        chk("arst_en",    128'(a_en),    128'd0);
        chk("arst_done",  128'(a_done),  128'd0);
        chk("arst_ready", 128'(a_ready), 128'd1);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_done) dn++;
        end
        chk_i("arst_no_done", dn, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 128'(a_ready), 128'd1);
        q = 128'hCAFEF00D_13579BDF_2468ACE0_55AA33CC;
        run_a(q, got, en_n, first_en, done_n, done_at, rdy_low);
        chk("post_rst_word",   got, q);
        chk_i("post_rst_done", done_n, 1);
        chk_i("post_rst_at",   done_at, WA);

`ifdef SB_SERIALIZER_PKT_CNT_EN
        run_a(128'h3, got, en_n, first_en, done_n, done_at, rdy_low);
        run_a(128'h7, got, en_n, first_en, done_n, done_at, rdy_low);
        chk("pkt_cnt_3", 128'(a_cnt), 128'd3);
        @(negedge clk);
        force dut_a.r_pkt_cnt = 16'hFFFF;
        #1;
        release dut_a.r_pkt_cnt;
        chk("pkt_cnt_pre", 128'(a_cnt), 128'hFFFF);
        run_a(128'h9, got, en_n, first_en, done_n, done_at, rdy_low);
        run_a(128'hB, got, en_n, first_en, done_n, done_at, rdy_low);
        chk("pkt_cnt_wrap", 128'(a_cnt), 128'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
